// File: rtl/my_exp_mod_pkg.sv
// Shared constants and engine state type for the RSA arithmetic core.
package my_exp_mod_pkg;

    localparam int C_BASE_W = 8;
    localparam int C_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } eng_state_t;

endpackage

// File: rtl/my_mod_divider.sv
// Restoring remainder unit: {1-bit, DATA_W-bit} dividend by DATA_W-bit divisor,
// one dividend bit per clock, MSB first, with load/done handshake.
module my_mod_divider
    import my_exp_mod_pkg::*;
#(
    parameter int DATA_W = C_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W:0]   i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_remainder,
    output logic              o_done
);

    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] C_ITER = CNT_W'(DATA_W + 1);

    eng_state_t        r_state;
    logic [DATA_W:0]   r_dividend;
    logic [DATA_W-1:0] r_divisor;
    logic [DATA_W-1:0] r_rem;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_result;
    logic              r_done;

    logic [DATA_W:0]   w_shift;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_next;

    // The partial remainder stays below a nonzero divisor, so the low-bit
    // subtraction is exact; a zero divisor simply shifts the dividend through.
    assign w_shift    = {r_rem, r_dividend[DATA_W]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_rem_next = w_ge ? (w_shift[DATA_W-1:0] - r_divisor) : w_shift[DATA_W-1:0];

    // Load restarts from any state; BUSY iterates DATA_W+1 bits then publishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
        end else if (i_load) begin
            r_state    <= BUSY;
            r_dividend <= i_dividend;
            r_divisor  <= i_divisor;
            r_rem      <= '0;
            r_cnt      <= C_ITER;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_rem      <= w_rem_next;
                        r_dividend <= r_dividend << 1;
                        r_cnt      <= r_cnt - 1'b1;
                    end else begin
                        r_result <= r_rem;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_remainder = r_result;
    assign o_done      = r_done;

endmodule

// File: rtl/my_exp_mod.sv
// RSA arithmetic core: iterative exponent engine plus independent modulus engine.
module my_exp_mod
    import my_exp_mod_pkg::*;
#(
    parameter int BASE_W = C_BASE_W,
    parameter int DATA_W = C_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BASE_W-1:0] exp_in,
    input  logic [BASE_W-1:0] exponent,
    input  logic              exp_load,
    input  logic              exp_cin,
    output logic [DATA_W-1:0] exp_result,
    output logic              exp_done,
    output logic              exp_cout,
    input  logic [DATA_W-1:0] mod_in,
    input  logic [DATA_W-1:0] modulus,
    input  logic              mod_load,
    input  logic              mod_cin,
    output logic [DATA_W-1:0] mod_result,
    output logic              mod_done
);

    localparam int PROD_W = DATA_W + BASE_W;

    eng_state_t        r_exp_state;
    logic [DATA_W-1:0] r_acc;
    logic [BASE_W-1:0] r_cnt;
    logic [BASE_W-1:0] r_base;
    logic              r_ovf;
    logic [DATA_W-1:0] r_exp_result;
    logic              r_exp_done;
    logic              r_exp_cout;

    logic [PROD_W-1:0] w_product;
    logic              w_prod_ovf;

    assign w_product  = PROD_W'(r_acc) * PROD_W'(r_base);
    assign w_prod_ovf = |w_product[PROD_W-1:DATA_W];

    // Exponent engine: one multiply per edge while cnt!=0, publish on cnt==0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_state  <= IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_base       <= '0;
            r_ovf        <= 1'b0;
            r_exp_result <= '0;
            r_exp_done   <= 1'b0;
            r_exp_cout   <= 1'b0;
        end else if (exp_load) begin
            r_exp_state <= BUSY;
            r_acc       <= DATA_W'(1);
            r_cnt       <= exponent;
            r_base      <= exp_in;
            r_ovf       <= exp_cin;
            r_exp_done  <= 1'b0;
        end else begin
            case (r_exp_state)
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_acc <= w_product[DATA_W-1:0];
                        r_ovf <= r_ovf | w_prod_ovf;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_exp_result <= r_acc;
                        r_exp_cout   <= r_ovf;
                        r_exp_done   <= 1'b1;
                        r_exp_state  <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign exp_result = r_exp_result;
    assign exp_done   = r_exp_done;
    assign exp_cout   = r_exp_cout;

    my_mod_divider #(
        .DATA_W (DATA_W)
    ) u_mod_divider (
        .clk         (clk),
        .rst         (rst),
        .i_load      (mod_load),
        .i_dividend  ({mod_cin, mod_in}),
        .i_divisor   (modulus),
        .o_remainder (mod_result),
        .o_done      (mod_done)
    );

endmodule

// File: tb/tb_my_exp_mod.sv
// Directed self-checking bench for my_exp_mod.
module tb_my_exp_mod;

    logic        clk;
    logic        rst;
    logic [7:0]  exp_in;
    logic [7:0]  exponent;
    logic        exp_load;
    logic        exp_cin;
    logic [15:0] exp_result;
    logic        exp_done;
    logic        exp_cout;
    logic [15:0] mod_in;
    logic [15:0] modulus;
    logic        mod_load;
    logic        mod_cin;
    logic [15:0] mod_result;
    logic        mod_done;

    int n_assert;
    int n_fail;
    int n_edges;

    my_exp_mod dut (
        .clk        (clk),
        .rst        (rst),
        .exp_in     (exp_in),
        .exponent   (exponent),
        .exp_load   (exp_load),
        .exp_cin    (exp_cin),
        .exp_result (exp_result),
        .exp_done   (exp_done),
        .exp_cout   (exp_cout),
        .mod_in     (mod_in),
        .modulus    (modulus),
        .mod_load   (mod_load),
        .mod_cin    (mod_cin),
        .mod_result (mod_result),
        .mod_done   (mod_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
        $display("check %-22s observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_go(input logic [7:0] b, input logic [7:0] e, input logic c);
        exp_in   = b;
        exponent = e;
        exp_cin  = c;
        exp_load = 1'b1;
        tick();
        exp_load = 1'b0;
    endtask

    task automatic mod_go(input logic [15:0] d, input logic [15:0] m, input logic c);
        mod_in   = d;
        modulus  = m;
        mod_cin  = c;
        mod_load = 1'b1;
        tick();
        mod_load = 1'b0;
    endtask

    // Edges counted from just after the load edge until done, bounded at 100.
    task automatic wait_exp(output int n);
        n = 0;
        while (exp_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_mod(output int n);
        n = 0;
        while (mod_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        exp_in   = '0;
        exponent = '0;
        exp_load = 1'b0;
        exp_cin  = 1'b0;
        mod_in   = '0;
        modulus  = '0;
        mod_load = 1'b0;
        mod_cin  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_exp_result", 32'(exp_result), 0);
        chk("rst_exp_done",   32'(exp_done),   0);
        chk("rst_exp_cout",   32'(exp_cout),   0);
        chk("rst_mod_result", 32'(mod_result), 0);
        chk("rst_mod_done",   32'(mod_done),   0);
        rst = 1'b0;
        tick();

        // 9^3 = 729, four edges
        exp_go(8'd9, 8'd3, 1'b0);
        chk("exp93_done_at_load", 32'(exp_done), 0);
        wait_exp(n_edges);
        chk("exp93_latency", 32'(n_edges), 4);
        chk("exp93_result",  32'(exp_result), 729);
        chk("exp93_cout",    32'(exp_cout), 0);

        // 729 mod 33 = 3, eighteen edges; exponent result holds meanwhile
        mod_go(16'd729, 16'd33, 1'b0);
        chk("mod729_done_at_load", 32'(mod_done), 0);
        wait_mod(n_edges);
        chk("mod729_latency", 32'(n_edges), 18);
        chk("mod729_result",  32'(mod_result), 3);
        chk("exp_hold_result", 32'(exp_result), 729);
        chk("exp_hold_done",   32'(exp_done), 1);

        // 255^3 overflows: low 16 bits 767, carry-out set
        exp_go(8'd255, 8'd3, 1'b0);
        wait_exp(n_edges);
        chk("exp255_latency", 32'(n_edges), 4);
        chk("exp255_result",  32'(exp_result), 767);
        chk("exp255_cout",    32'(exp_cout), 1);

        // Exponent zero gives 1 after a single edge
        exp_go(8'd0, 8'd0, 1'b0);
        wait_exp(n_edges);
        chk("exp00_latency", 32'(n_edges), 1);
        chk("exp00_result",  32'(exp_result), 1);
        chk("exp00_cout",    32'(exp_cout), 0);

        // Carry-in presets overflow even without a large product
        exp_go(8'd2, 8'd2, 1'b1);
        wait_exp(n_edges);
        chk("expcin_result", 32'(exp_result), 4);
        chk("expcin_cout",   32'(exp_cout), 1);

        // 17-bit dividend 65536 mod 33 = 31
        mod_go(16'd0, 16'd33, 1'b1);
        wait_mod(n_edges);
        chk("modcin_latency", 32'(n_edges), 18);
        chk("modcin_result",  32'(mod_result), 31);

        // Modulus zero passes the dividend through
        mod_go(16'd1234, 16'd0, 1'b0);
        wait_mod(n_edges);
        chk("mod0_latency", 32'(n_edges), 18);
        chk("mod0_result",  32'(mod_result), 1234);

        // Coincident loads: 3^4 = 81 and 100 mod 7 = 2
        exp_in   = 8'd3;
        exponent = 8'd4;
        exp_cin  = 1'b0;
        mod_in   = 16'd100;
        modulus  = 16'd7;
        mod_cin  = 1'b0;
        exp_load = 1'b1;
        mod_load = 1'b1;
        tick();
        exp_load = 1'b0;
        mod_load = 1'b0;
        wait_mod(n_edges);
        chk("both_mod_latency", 32'(n_edges), 18);
        chk("both_mod_result",  32'(mod_result), 2);
        chk("both_exp_done",    32'(exp_done), 1);
        chk("both_exp_result",  32'(exp_result), 81);

        // Reset mid-BUSY clears outputs without waiting for a clock edge
        exp_go(8'd9, 8'd3, 1'b0);
        mod_go(16'd729, 16'd33, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_exp_result", 32'(exp_result), 0);
        chk("arst_mod_result", 32'(mod_result), 0);
        chk("arst_exp_done",   32'(exp_done), 0);
        tick();
        rst = 1'b0;
        repeat (25) tick();
        chk("arst_no_exp_done", 32'(exp_done), 0);
        chk("arst_no_mod_done", 32'(mod_done), 0);

        // Re-load after reset
        exp_go(8'd9, 8'd3, 1'b0);
        wait_exp(n_edges);
        chk("reload_latency", 32'(n_edges), 4);
        chk("reload_result",  32'(exp_result), 729);

        // Re-load during BUSY restarts and drops done
        exp_go(8'd2, 8'd5, 1'b0);
        chk("restart_done_drop", 32'(exp_done), 0);
        tick();
        tick();
        exp_go(8'd3, 8'd2, 1'b0);
        wait_exp(n_edges);
        chk("restart_latency", 32'(n_edges), 3);
        chk("restart_result",  32'(exp_result), 9);

        // Held load keeps done low; latency counts from the last load edge
        exp_in   = 8'd4;
        exponent = 8'd2;
        exp_load = 1'b1;
        tick();
        chk("held_done_1", 32'(exp_done), 0);
        tick();
        tick();
        chk("held_done_3", 32'(exp_done), 0);
        exp_load = 1'b0;
        wait_exp(n_edges);
        chk("held_latency", 32'(n_edges), 3);
        chk("held_result",  32'(exp_result), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
